// File: rtl/key_session_ctrl.sv
// Session controller: sequences load/round/result handshake per accepted
// key command, counts completed words and flags commands sent while the
// session is closed.
// Ports: Clk, Reset (async, active-high), Active, Mode, ValidCmd, OutReady
//   -> LoadEn, RoundEn, RoundIdx, ModeLatched, OutValid, Done, Abort,
//      CmdReject, Busy, WordCnt, SessionEnd.
// Optional: define KEY_SESSION_TIMEOUT_EN for the idle-timeout SessionEnd.
module key_session_ctrl #(
  parameter int ROUNDS         = 4,
  parameter int RIDX_W         = 4,
  parameter int WCNT_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Active,
  input  logic              Mode,
  input  logic              ValidCmd,
  input  logic              OutReady,
  output logic              LoadEn,
  output logic              RoundEn,
  output logic [RIDX_W-1:0] RoundIdx,
  output logic              ModeLatched,
  output logic              OutValid,
  output logic              Done,
  output logic              Abort,
  output logic              CmdReject,
  output logic              Busy,
  output logic [WCNT_W-1:0] WordCnt,
  output logic              SessionEnd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [RIDX_W-1:0] LAST = RIDX_W'(ROUNDS - 1);

  logic [1:0]        state;
  logic [RIDX_W-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ModeLatched <= 1'b0;
      WordCnt     <= '0;
      Done        <= 1'b0;
      Abort       <= 1'b0;
      CmdReject   <= 1'b0;
    end else begin
      Done      <= 1'b0;
      Abort     <= 1'b0;
      CmdReject <= 1'b0;
      case (state)
        IDLE: begin
          if (ValidCmd && Active) begin
            state       <= LOAD;
            ModeLatched <= Mode;
          end else if (ValidCmd) begin
            CmdReject <= 1'b1;
          end
        end
        LOAD: begin
          if (!Active) begin
            state <= IDLE;
            Abort <= 1'b1;
          end else begin
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (!Active) begin
            state <= IDLE;
            Abort <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= HOLD;
          end
        end
        default: begin
          // A dropped session still lets the held result drain.
          if (OutReady) begin
            Done    <= 1'b1;
            WordCnt <= WordCnt + 1'b1;
            if (Active && ValidCmd) begin
              state       <= LOAD;
              ModeLatched <= Mode;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign LoadEn   = (state == LOAD);
  assign RoundEn  = (state == RUN);
  assign OutValid = (state == HOLD);
  assign Busy     = (state != IDLE);
  assign RoundIdx = !RoundEn    ? '0 :
                    ModeLatched ? LAST - cnt : cnt;

`ifdef KEY_SESSION_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idle_cnt   <= '0;
      SessionEnd <= 1'b0;
    end else begin
      SessionEnd <= 1'b0;
      if (state == IDLE && Active && !ValidCmd) begin
        if (idle_cnt == TLAST) begin
          idle_cnt   <= '0;
          SessionEnd <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign SessionEnd     = 1'b0;
`endif

endmodule

// File: tb/tb_key_session_ctrl.sv
// Directed bench for key_session_ctrl (ROUNDS=4, WCNT_W=8, TIMEOUT=16).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_key_session_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Active, Mode, ValidCmd, OutReady;
  logic       LoadEn, RoundEn, ModeLatched, OutValid;
  logic       Done, Abort, CmdReject, Busy, SessionEnd;
  logic [3:0] RoundIdx;
  logic [7:0] WordCnt;

  int n_chk  = 0;
  int n_pass = 0;

  key_session_ctrl #(
    .ROUNDS(4), .RIDX_W(4), .WCNT_W(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Active(Active), .Mode(Mode),
    .ValidCmd(ValidCmd), .OutReady(OutReady), .LoadEn(LoadEn),
    .RoundEn(RoundEn), .RoundIdx(RoundIdx), .ModeLatched(ModeLatched),
    .OutValid(OutValid), .Done(Done), .Abort(Abort),
    .CmdReject(CmdReject), .Busy(Busy), .WordCnt(WordCnt),
    .SessionEnd(SessionEnd)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Accept one forward command and drain it with OutReady held high.
  task automatic run_cmd();
    ValidCmd = 1'b1;
    tick();
    ValidCmd = 1'b0;
    repeat (5) tick();
    tick();
  endtask

  initial begin
    Reset = 1'b1; Active = 1'b0; Mode = 1'b0;
    ValidCmd = 1'b0; OutReady = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_load", LoadEn, 0);
    chk("rst_round", RoundEn, 0);
    chk("rst_valid", OutValid, 0);
    chk("rst_wcnt", WordCnt, 0);
    chk("rst_pulses", {Done, Abort, CmdReject, SessionEnd}, 0);
    chk("rst_mode", ModeLatched, 0);

    // forward command
    Active = 1'b1; Mode = 1'b0; OutReady = 1'b1; ValidCmd = 1'b1;
    tick();
    ValidCmd = 1'b0;
    chk("fw_load", LoadEn, 1);
    chk("fw_busy", Busy, 1);
    chk("fw_noround", RoundEn, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fw_round", RoundEn, 1);
      chk("fw_idx", RoundIdx, i);
      chk("fw_noload", LoadEn, 0);
    end
    tick();
    chk("fw_valid", OutValid, 1);
    chk("fw_idx_out", RoundIdx, 0);
    tick();
    chk("fw_done", Done, 1);
    chk("fw_wcnt", WordCnt, 1);
    chk("fw_idle", Busy, 0);
    tick();
    chk("fw_done_pulse", Done, 0);

    // reverse command, Mode flips after accept
    Mode = 1'b1; ValidCmd = 1'b1;
    tick();
    ValidCmd = 1'b0; Mode = 1'b0;
    chk("rv_mode", ModeLatched, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rv_idx", RoundIdx, 3 - i);
      chk("rv_mode_hold", ModeLatched, 1);
    end
    tick();
    chk("rv_valid", OutValid, 1);
    tick();
    chk("rv_wcnt", WordCnt, 2);

    // backpressure in HOLD then back-to-back accept
    OutReady = 1'b0; ValidCmd = 1'b1;
    tick();
    ValidCmd = 1'b0;
    chk("bp_mode", ModeLatched, 0);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", OutValid, 1);
      chk("bp_nodone", Done, 0);
      if (i < 3) tick();
    end
    OutReady = 1'b1; ValidCmd = 1'b1; Mode = 1'b1;
    tick();
    ValidCmd = 1'b0;
    chk("bb_done", Done, 1);
    chk("bb_load", LoadEn, 1);
    chk("bb_mode", ModeLatched, 1);
    chk("bb_wcnt", WordCnt, 3);

    // ValidCmd during RUN is ignored, then abort at RoundIdx 2
    tick();
    chk("ab_idx3", RoundIdx, 3);
    ValidCmd = 1'b1;
    tick();
    ValidCmd = 1'b0;
    chk("ab_idx2", RoundIdx, 2);
    chk("ab_norej", CmdReject, 0);
    Active = 1'b0;
    tick();
    chk("ab_abort", Abort, 1);
    chk("ab_busy", Busy, 0);
    chk("ab_valid", OutValid, 0);
    chk("ab_wcnt", WordCnt, 3);
    tick();
    chk("ab_pulse", Abort, 0);

    // reject in IDLE
    ValidCmd = 1'b1;
    tick();
    ValidCmd = 1'b0;
    chk("rj_rej", CmdReject, 1);
    chk("rj_busy", Busy, 0);
    tick();
    chk("rj_pulse", CmdReject, 0);

    // asynchronous reset mid-RUN
    Active = 1'b1; Mode = 1'b1; ValidCmd = 1'b1;
    tick();
    ValidCmd = 1'b0;
    tick(); tick();
    chk("ar_run", RoundEn, 1);
    Reset = 1'b1;
    #1;
    chk("ar_busy", Busy, 0);
    chk("ar_round", RoundEn, 0);
    chk("ar_wcnt", WordCnt, 0);
    chk("ar_mode", ModeLatched, 0);
    tick();
    Reset = 1'b0; Mode = 1'b0;
    tick();

    // WordCnt wrap
    for (int i = 0; i < 255; i++) run_cmd();
    chk("wr_255", WordCnt, 255);
    run_cmd();
    chk("wr_wrap", WordCnt, 0);

    // idle timeout
    Active = 1'b0;
    tick();
    Active = 1'b1;
`ifdef KEY_SESSION_TIMEOUT_EN
    repeat (15) tick();
    chk("to_early", SessionEnd, 0);
    tick();
    chk("to_fire", SessionEnd, 1);
    tick();
    chk("to_pulse", SessionEnd, 0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("to_off", SessionEnd, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
